// File: rtl/activation_pipe.sv
// Two-stage activation + requantization pipeline (S1 activation, S2 round/saturate/clamp).
// Define ACTIVATION_PIPE_SAT_CNT_EN to enable the saturated-vector counter on sat_count.
module activation_pipe #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 8,
  parameter int CH      = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cfg_mode,
  input  logic [SHIFT_W-1:0]    cfg_shift,
  input  logic [SHIFT_W-1:0]    cfg_leak_shift,
  input  logic [OUT_W-2:0]      cfg_clamp_max,
  input  logic [CH*IN_W-1:0]    in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_count,
  output logic [15:0]           sat_count
);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_CLAMP  = 2'd3
  } mode_t;

  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

  logic                  s1_valid;
  logic [CH*IN_W-1:0]    s1_y;
  mode_t                 s1_mode;
  logic [SHIFT_W-1:0]    s1_shift;
  logic [OUT_W-2:0]      s1_clamp;

  logic                  s1_adv;
  logic                  s2_adv;
  logic [CH*IN_W-1:0]    s1_next;
  logic [CH*OUT_W-1:0]   s2_next;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // S1: activation in the full accumulator domain
  always_comb begin
    logic signed [IN_W-1:0] x;
    logic signed [IN_W-1:0] y;
    s1_next = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      x = in_data[c*IN_W +: IN_W];
      y = x;
      case (mode_t'(cfg_mode))
        MODE_BYPASS: y = x;
        MODE_LEAKY:  y = x[IN_W-1] ? (x >>> cfg_leak_shift) : x;
        default:     y = x[IN_W-1] ? '0 : x;
      endcase
      s1_next[c*IN_W +: IN_W] = y;
    end
  end

`ifdef ACTIVATION_PIPE_SAT_CNT_EN
  logic s2_any_sat;
  logic s2_sat;
`endif

  // S2: round-half-up shift in IN_W+1 bits; bias is zero when shift is zero
  always_comb begin
    logic signed [IN_W:0]    ye;
    logic        [IN_W:0]    bias;
    logic signed [IN_W:0]    r;
    logic signed [OUT_W-1:0] v;
    logic signed [OUT_W-1:0] cmax;
    s2_next = '0;
`ifdef ACTIVATION_PIPE_SAT_CNT_EN
    s2_any_sat = 1'b0;
`endif
    cmax = {1'b0, s1_clamp};
    for (int unsigned c = 0; c < CH; c++) begin
      ye   = {s1_y[c*IN_W+IN_W-1], s1_y[c*IN_W +: IN_W]};
      bias = ((IN_W+1)'(1) << s1_shift) >> 1;
      r    = (ye + $signed(bias)) >>> s1_shift;
      if (r > SAT_MAX)      v = SAT_MAX[OUT_W-1:0];
      else if (r < SAT_MIN) v = SAT_MIN[OUT_W-1:0];
      else                  v = r[OUT_W-1:0];
`ifdef ACTIVATION_PIPE_SAT_CNT_EN
      s2_any_sat = s2_any_sat | (r > SAT_MAX) | (r < SAT_MIN);
`endif
      if (s1_mode == MODE_CLAMP) begin
        if (v < 0)         v = '0;
        else if (v > cmax) v = cmax;
      end
      s2_next[c*OUT_W +: OUT_W] = v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
      s1_mode  <= MODE_BYPASS;
      s1_shift <= '0;
      s1_clamp <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_y     <= s1_next;
        s1_mode  <= mode_t'(cfg_mode);
        s1_shift <= cfg_shift;
        s1_clamp <= cfg_clamp_max;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) out_data <= s2_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         out_count <= '0;
    else if (out_valid && out_ready) out_count <= out_count + 16'd1;
  end

`ifdef ACTIVATION_PIPE_SAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         s2_sat <= 1'b0;
    else if (s2_adv && s1_valid)     s2_sat <= s2_any_sat;
  end

  // Sticky at all-ones rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_count <= '0;
    else if (out_valid && out_ready && s2_sat && (sat_count != '1))
      sat_count <= sat_count + 16'd1;
  end
`else
  assign sat_count = '0;
`endif

endmodule
